stripe_pingpong_ctrl: RTL and testbench



---
 rtl/jpeg_hdmi_pkg.sv | 25 ++
 rtl/stripe_addr_gen.sv | 73 +++++++
 rtl/stripe_pingpong_ctrl.sv | 128 ++++++++++++
 tb/tb_stripe_pingpong_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_hdmi_pkg.sv
// Shared types and sizing helpers for the decoder-to-HDMI stripe buffering.
package jpeg_hdmi_pkg;

  localparam int unsigned BLOCK_SIZE = 8;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    FULL,
    DRAINING
  } buf_state_t;

  function automatic int unsigned addr_w(input int unsigned x_res, input int unsigned n);
    return $clog2(x_res * BLOCK_SIZE / n);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned count);
    return (count > 1) ? $clog2(count) : 1;
  endfunction

  function automatic logic [1:0] buf_sel(input logic ptr);
    return ptr ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/stripe_addr_gen.sv
// Stripe address counter: block-ordered (elem/line/block) for writes, or linear
// (col/line) for raster reads. The address is registered on each step.
module stripe_addr_gen
  import jpeg_hdmi_pkg::*;
#(
  parameter int unsigned X_RES  = 2160,
  parameter int unsigned N      = 2,
  parameter int unsigned ADDR_W = addr_w(X_RES, N),
  parameter bit          LINEAR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              clr,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int unsigned LINE_BEATS = X_RES / N;
  localparam int unsigned C0_N       = LINEAR ? LINE_BEATS : BLOCK_SIZE / N;
  localparam int unsigned C2_N       = LINEAR ? 1 : X_RES / BLOCK_SIZE;
  localparam int unsigned C0_W       = cnt_w(C0_N);
  localparam int unsigned C2_W       = cnt_w(C2_N);
  localparam int unsigned SUM_W      = ADDR_W + 1;

  localparam logic [C0_W-1:0] C0_MAX = C0_W'(C0_N - 1);
  localparam logic [2:0]      C1_MAX = 3'(BLOCK_SIZE - 1);
  localparam logic [C2_W-1:0] C2_MAX = C2_W'(C2_N - 1);

  logic [C0_W-1:0]  c0_q, c0_e, c0_d;
  logic [2:0]       c1_q, c1_e, c1_d;
  logic [C2_W-1:0]  c2_q, c2_e, c2_d;
  logic             c0_wrap, c1_wrap, c2_wrap;
  logic [SUM_W-1:0] sum;

  always_comb begin
    c0_e    = clr ? '0 : c0_q;
    c1_e    = clr ? '0 : c1_q;
    c2_e    = clr ? '0 : c2_q;
    c0_wrap = (c0_e == C0_MAX);
    c1_wrap = (c1_e == C1_MAX);
    c2_wrap = (c2_e == C2_MAX);
    last    = LINEAR ? c0_wrap : (c0_wrap && c1_wrap && c2_wrap);

    c0_d = c0_wrap ? '0 : c0_e + 1'b1;
    c1_d = c1_e;
    c2_d = c2_e;
    if (c0_wrap) begin
      c1_d = c1_wrap ? '0 : c1_e + 1'b1;
      if (c1_wrap) begin
        c2_d = c2_wrap ? '0 : c2_e + 1'b1;
      end
    end

    sum = SUM_W'(c0_e) + SUM_W'(c1_e) * SUM_W'(LINE_BEATS) + SUM_W'(c2_e) * SUM_W'(C0_N);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c0_q <= '0;
      c1_q <= '0;
      c2_q <= '0;
      addr <= '0;
    end else if (step) begin
      c0_q <= c0_d;
      c1_q <= c1_d;
      c2_q <= c2_d;
      // A carry out would mean the counters left the stripe; park at 0.
      addr <= sum[ADDR_W] ? '0 : sum[ADDR_W-1:0];
    end
  end

endmodule

// File: rtl/stripe_pingpong_ctrl.sv
// Two-stripe ping-pong controller: block-ordered fills, raster-line drains,
// per-buffer ownership tracking, back-pressure and underrun/overflow flags.
module stripe_pingpong_ctrl
  import jpeg_hdmi_pkg::*;
#(
  parameter int unsigned N      = 2,
  parameter int unsigned X_RES  = 2160,
  parameter int unsigned Y_RES  = 1200,
  parameter int unsigned ADDR_W = addr_w(X_RES, N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid,
  output logic              blk_ready,
  input  logic              blk_sof,
  output logic [1:0]        wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              rd_line_req,
  output logic [1:0]        rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_line_done,
  output logic              rd_frame_last,
  output logic              underrun,
  output logic              overflow_sof
);

  localparam int unsigned STRIPES  = Y_RES / BLOCK_SIZE;
  localparam int unsigned STRIPE_W = cnt_w(STRIPES);
  localparam logic [STRIPE_W-1:0] STRIPE_LAST = STRIPE_W'(STRIPES - 1);

  buf_state_t          state_q [2];
  logic                wr_ptr_q, rd_ptr_q;
  logic                rd_run_q, rd_rel_q;
  logic [2:0]          rd_line_cnt_q;
  logic [STRIPE_W-1:0] stripe_q;

  logic wr_acc, wr_last;
  logic rd_avail, rd_busy, rd_start, rd_step, rd_line_end;

  always_comb begin
    blk_ready     = (state_q[wr_ptr_q] == FREE) || (state_q[wr_ptr_q] == FILLING);
    wr_acc        = blk_valid && blk_ready;
    rd_avail      = (state_q[rd_ptr_q] == FULL) || (state_q[rd_ptr_q] == DRAINING);
    // Busy until the final beat of the current line has been presented.
    rd_busy       = rd_run_q || (rd_en != 2'b00);
    rd_start      = rd_line_req && !rd_busy && rd_avail;
    rd_step       = rd_start || rd_run_q;
    rd_frame_last = (stripe_q == STRIPE_LAST) && (state_q[rd_ptr_q] == DRAINING);
  end

  stripe_addr_gen #(
    .X_RES (X_RES),
    .N     (N),
    .ADDR_W(ADDR_W),
    .LINEAR(1'b0)
  ) u_wr_gen (
    .clk (clk),
    .rst (rst),
    .step(wr_acc),
    .clr (blk_sof),
    .addr(wr_addr),
    .last(wr_last)
  );

  stripe_addr_gen #(
    .X_RES (X_RES),
    .N     (N),
    .ADDR_W(ADDR_W),
    .LINEAR(1'b1)
  ) u_rd_gen (
    .clk (clk),
    .rst (rst),
    .step(rd_step),
    .clr (1'b0),
    .addr(rd_addr),
    .last(rd_line_end)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q[0]    <= FREE;
      state_q[1]    <= FREE;
      wr_ptr_q      <= 1'b0;
      rd_ptr_q      <= 1'b0;
      rd_run_q      <= 1'b0;
      rd_rel_q      <= 1'b0;
      rd_line_cnt_q <= '0;
      stripe_q      <= '0;
      wr_en         <= 2'b00;
      rd_en         <= 2'b00;
      rd_line_done  <= 1'b0;
      underrun      <= 1'b0;
      overflow_sof  <= 1'b0;
    end else begin
      wr_en        <= wr_acc ? buf_sel(wr_ptr_q) : 2'b00;
      overflow_sof <= wr_acc && blk_sof && (state_q[wr_ptr_q] == FILLING);
      if (wr_acc) begin
        if (wr_last) begin
          state_q[wr_ptr_q] <= FULL;
          wr_ptr_q          <= !wr_ptr_q;
        end else begin
          state_q[wr_ptr_q] <= FILLING;
        end
      end

      rd_en        <= rd_step ? buf_sel(rd_ptr_q) : 2'b00;
      rd_line_done <= rd_step && rd_line_end;
      rd_rel_q     <= rd_step && rd_line_end && (rd_line_cnt_q == 3'd7);
      underrun     <= rd_line_req && !rd_busy && !rd_avail;
      if (rd_step) begin
        rd_run_q <= !rd_line_end;
      end
      if (rd_step && rd_line_end) begin
        rd_line_cnt_q <= rd_line_cnt_q + 3'd1;
      end
      if (rd_start && (state_q[rd_ptr_q] == FULL)) begin
        state_q[rd_ptr_q] <= DRAINING;
      end
      // Release lands after the last beat, so the writer sees FREE a cycle later.
      if (rd_rel_q) begin
        state_q[rd_ptr_q] <= FREE;
        rd_ptr_q          <= !rd_ptr_q;
        stripe_q          <= (stripe_q == STRIPE_LAST) ? '0 : stripe_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stripe_pingpong_ctrl.sv
// Scoreboard bench for stripe_pingpong_ctrl at X_RES=32, Y_RES=16, N=2.
module tb_stripe_pingpong_ctrl;

  localparam int unsigned N      = 2;
  localparam int unsigned X_RES  = 32;
  localparam int unsigned Y_RES  = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned LB     = 16;

  logic              clk = 1'b0;
  logic              rst, blk_valid, blk_sof, rd_line_req;
  logic              blk_ready, rd_line_done, rd_frame_last, underrun, overflow_sof;
  logic [1:0]        wr_en, rd_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;

  int total = 0;
  int bad   = 0;

  logic [8:0]  wr_q [$];  // {en, addr}
  logic [10:0] rd_q [$];  // {en, addr, done, frame_last}
  logic [1:0]  ovf_q [$];
  bit          und_q [$];
  logic [8:0]  wexp;
  logic [10:0] rexp;
  logic [1:0]  oexp;
  bit          uexp;

  always #5 clk = ~clk;

  stripe_pingpong_ctrl #(
    .N    (N),
    .X_RES(X_RES),
    .Y_RES(Y_RES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blk_valid    (blk_valid),
    .blk_ready    (blk_ready),
    .blk_sof      (blk_sof),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .rd_line_req  (rd_line_req),
    .rd_en        (rd_en),
    .rd_addr      (rd_addr),
    .rd_line_done (rd_line_done),
    .rd_frame_last(rd_frame_last),
    .underrun     (underrun),
    .overflow_sof (overflow_sof)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT presents an output event.
  always @(negedge clk) begin
    if (wr_en != 2'b00) begin
      if (wr_q.size() == 0) chk("wr_unexpected", int'(wr_en), 0);
      else begin
        wexp = wr_q.pop_front();
        chk("wr_en", wr_en, wexp[8:7]);
        chk("wr_addr", wr_addr, wexp[6:0]);
      end
    end
    if (rd_en != 2'b00) begin
      if (rd_q.size() == 0) chk("rd_unexpected", int'(rd_en), 0);
      else begin
        rexp = rd_q.pop_front();
        chk("rd_en", rd_en, rexp[10:9]);
        chk("rd_addr", rd_addr, rexp[8:2]);
        chk("rd_line_done", rd_line_done, rexp[1]);
        chk("rd_frame_last", rd_frame_last, rexp[0]);
      end
    end else if (rd_line_done) begin
      chk("rd_done_stray", rd_line_done, 0);
    end
    if (underrun) begin
      if (und_q.size() == 0) chk("underrun_unexpected", underrun, 0);
      else begin
        uexp = und_q.pop_front();
        chk("underrun_rd_en", rd_en, 0);
      end
    end
    if (overflow_sof) begin
      if (ovf_q.size() == 0) chk("ovf_unexpected", overflow_sof, 0);
      else begin
        oexp = ovf_q.pop_front();
        chk("ovf_wr_en", wr_en, oexp);
        chk("ovf_wr_addr", wr_addr, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int wr_model(input int k);
    return (k % 4) + ((k / 4) % 8) * LB + (k / 32) * 4;
  endfunction

  task automatic send_beat(input logic sof, input int addr, input logic [1:0] en, input bit ovf);
    int n = 0;
    blk_valid = 1'b1;
    blk_sof   = sof;
    @(negedge clk);
    while (!blk_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!blk_ready) chk("beat_timeout", blk_ready, 1);
    else begin
      wr_q.push_back({en, addr[6:0]});
      if (ovf) ovf_q.push_back(en);
    end
    tick();
    blk_valid = 1'b0;
    blk_sof   = 1'b0;
  endtask

  task automatic fill(input logic [1:0] en);
    for (int k = 0; k < 128; k++) send_beat(1'b0, wr_model(k), en, 1'b0);
  endtask

  task automatic read_line(input bit ok, input int line, input logic [1:0] en, input bit flast,
                           input bit extra, output logic rdy_at_done);
    int n = 0;
    rdy_at_done = 1'b0;
    rd_line_req = 1'b1;
    if (ok) begin
      for (int c = 0; c < LB; c++) rd_q.push_back({en, 7'(c + line * LB), c == LB - 1, flast});
    end else begin
      und_q.push_back(1'b1);
    end
    tick();
    rd_line_req = 1'b0;
    if (extra) begin
      repeat (3) tick();
      rd_line_req = 1'b1;
      tick();
      rd_line_req = 1'b0;
    end
    if (ok) begin
      @(negedge clk);
      while (!rd_line_done && n < 60) begin
        @(negedge clk);
        n++;
      end
      chk("line_done_seen", rd_line_done, 1);
      rdy_at_done = blk_ready;
      tick();
    end else begin
      repeat (3) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic r;
    int   n;
    rst = 1'b1; blk_valid = 1'b0; blk_sof = 1'b0; rd_line_req = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_blk_ready", blk_ready, 1);
    chk("rst_rd_line_done", rd_line_done, 0);
    chk("rst_frame_last", rd_frame_last, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_overflow", overflow_sof, 0);
    tick();

    // Line request with nothing buffered.
    read_line(1'b0, 0, 2'b01, 1'b0, 1'b0, r);
    chk("underrun_consumed", und_q.size(), 0);
    chk("rd_en_idle", rd_en, 0);

    // Fill both buffers; the next beat must stall.
    fill(2'b01);
    fill(2'b10);
    blk_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("ready_both_full", blk_ready, 0);
    end
    blk_valid = 1'b0;
    tick();

    // Drain buffer 0 (stripe 0), with an ignored mid-line request on line 2.
    for (int l = 0; l < 8; l++) read_line(1'b1, l, 2'b01, 1'b0, l == 2, r);
    chk("ready_at_8th_done", r, 0);
    @(negedge clk);
    chk("ready_after_release", blk_ready, 1);
    tick();

    // Drain buffer 1 (stripe 1, last of frame).
    for (int l = 0; l < 8; l++) read_line(1'b1, l, 2'b10, 1'b1, 1'b0, r);
    @(negedge clk);
    chk("frame_last_cleared", rd_frame_last, 0);
    tick();

    // Restart-of-frame in the middle of a fill.
    for (int k = 0; k < 50; k++) send_beat(k == 0, wr_model(k), 2'b01, 1'b0);
    send_beat(1'b1, 0, 2'b01, 1'b1);
    for (int k = 1; k < 128; k++) send_beat(1'b0, wr_model(k), 2'b01, 1'b0);
    @(negedge clk);
    chk("ovf_consumed", ovf_q.size(), 0);
    tick();

    // Stripe counter has wrapped: frame_last low again.
    read_line(1'b1, 0, 2'b01, 1'b0, 1'b0, r);

    // Reset in the middle of line 1 at rd_col=5.
    rd_line_req = 1'b1;
    for (int c = 0; c < 6; c++) rd_q.push_back({2'b01, 7'(c + LB), 1'b0, 1'b0});
    tick();
    rd_line_req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(rd_en != 2'b00 && rd_addr == 7'(5 + LB)) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("mid_read_col5", rd_addr, 5 + LB);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rd_en", rd_en, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_blk_ready", blk_ready, 1);
    chk("midrst_wr_en", wr_en, 0);
    tick();
    rst = 1'b0;
    chk("midrst_rd_q", rd_q.size(), 0);

    // Buffers must be FREE and pointers/counters back at 0.
    read_line(1'b0, 0, 2'b01, 1'b0, 1'b0, r);
    send_beat(1'b0, 0, 2'b01, 1'b0);
    send_beat(1'b0, 1, 2'b01, 1'b0);
    repeat (3) tick();

    chk("wr_q_drained", wr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("und_q_drained", und_q.size(), 0);
    chk("ovf_q_drained", ovf_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
